// File: rtl/bht_access_scheduler.sv
// Single-port BHT arbiter: fetch lookups, queued read-modify-write counter updates,
// and whole-table initialisation after reset or flush.
module bht_access_scheduler #(
    parameter int         LOWER      = 5,
    parameter int         QDEPTH     = 4,
    parameter logic [1:0] INIT_STATE = 2'b01
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             lookup_req,
    input  logic [LOWER-1:0] lookup_addr,
    output logic             lookup_ready,
    output logic             pred_valid,
    output logic             pred_taken,
    input  logic             upd_valid,
    input  logic [LOWER-1:0] upd_addr,
    input  logic             upd_taken,
    output logic             upd_ready,
    output logic             tbl_en,
    output logic             tbl_we,
    output logic [LOWER-1:0] tbl_addr,
    output logic [1:0]       tbl_wdata,
    input  logic [1:0]       tbl_rdata,
    output logic             busy
);
    localparam int PW = $clog2(QDEPTH);

    typedef enum logic [1:0] {CLEAR, IDLE, UPD_RD, UPD_WR} state_t;

    state_t           state;
    logic [LOWER-1:0] clr_cnt;
    logic             pred_q;

    logic [LOWER-1:0] q_addr  [QDEPTH];
    logic             q_taken [QDEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;

    logic full, empty, push, pop, lookup_acc;

    function automatic logic [1:0] sat_next(input logic [1:0] s, input logic taken);
        if (taken) return (s == 2'b11) ? 2'b11 : s + 2'b01;
        else       return (s == 2'b00) ? 2'b00 : s - 2'b01;
    endfunction

    assign full  = (count == (PW+1)'(QDEPTH));
    assign empty = (count == '0);

    assign lookup_ready = !rst && (state == IDLE) && lookup_req && !full;
    assign lookup_acc   = lookup_ready;
    assign upd_ready    = !rst && !full && (state != CLEAR);
    assign push         = upd_valid && upd_ready;
    assign pop          = !rst && (state == UPD_WR);

    assign busy       = (state == CLEAR);
    assign pred_valid = pred_q;
    // Read data arrives the cycle after the access, aligned with pred_q.
    assign pred_taken = pred_q & tbl_rdata[1];

    always_comb begin
        tbl_en    = 1'b0;
        tbl_we    = 1'b0;
        tbl_addr  = '0;
        tbl_wdata = INIT_STATE;
        if (!rst) begin
            case (state)
                CLEAR: begin
                    tbl_en   = 1'b1;
                    tbl_we   = 1'b1;
                    tbl_addr = clr_cnt;
                end
                IDLE: begin
                    if (lookup_acc) begin
                        tbl_en   = 1'b1;
                        tbl_addr = lookup_addr;
                    end
                end
                UPD_RD: begin
                    tbl_en   = 1'b1;
                    tbl_addr = q_addr[rd_ptr];
                end
                UPD_WR: begin
                    tbl_en    = 1'b1;
                    tbl_we    = 1'b1;
                    tbl_addr  = q_addr[rd_ptr];
                    tbl_wdata = sat_next(tbl_rdata, q_taken[rd_ptr]);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            clr_cnt <= '0;
            pred_q  <= 1'b0;
        end else begin
            pred_q <= lookup_acc;
            case (state)
                CLEAR: begin
                    if (flush) begin
                        clr_cnt <= '0;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                        if (clr_cnt == '1) state <= IDLE;
                    end
                end
                IDLE: begin
                    if (flush) begin
                        state   <= CLEAR;
                        clr_cnt <= '0;
                    end else if (!lookup_acc && !empty) begin
                        state <= UPD_RD;
                    end
                end
                UPD_RD: begin
                    if (flush) begin
                        state   <= CLEAR;
                        clr_cnt <= '0;
                    end else begin
                        state <= UPD_WR;
                    end
                end
                UPD_WR: begin
                    // The write issued this cycle completes even when flushing.
                    state   <= flush ? CLEAR : IDLE;
                    clr_cnt <= '0;
                end
                default: state <= CLEAR;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_addr[wr_ptr]  <= upd_addr;
            q_taken[wr_ptr] <= upd_taken;
        end
    end
endmodule

// File: doc/bht_access_scheduler.md
Name: bht_access_scheduler

Overview:
- Owns the single port of the 2-bit-per-entry branch history table (BHT) and shares it between two requesters: fetch-stage prediction lookups and execute-stage resolution updates.
- Queues resolved-branch updates and applies each one as a read-modify-write of a saturating 2-bit counter.
- Initialises every table entry after reset or on a flush.
- Sits between the fetch/execute pipeline stages and the table storage.

Parameters:
- LOWER, 5, PC index bits; the table has 2**LOWER entries.
- QDEPTH, 4, depth of the pending-update FIFO (power of two, ≥2).
- INIT_STATE, 2'b01, counter value written to every entry during clear.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  one-cycle pulse: discard queued updates and re-clear the table.
- lookup_req  in  1  fetch wants a prediction.
- lookup_addr  in  LOWER  fetch PC index.
- lookup_ready  out  1  lookup accepted this cycle when req&&ready.
- pred_valid  out  1  prediction valid (one cycle).
- pred_taken  out  1  predicted direction.
- upd_valid  in  1  resolved branch available.
- upd_addr  in  LOWER  index of resolved branch.
- upd_taken  in  1  actual outcome (taken or jumped).
- upd_ready  out  1  FIFO can accept (not full).
- tbl_en  out  1  table access enable.
- tbl_we  out  1  table write enable.
- tbl_addr  out  LOWER  table index.
- tbl_wdata  out  2  table write data.
- tbl_rdata  in  2  table read data, valid the cycle after a read.
- busy  out  1  high while clearing.

Behaviour:
- Reset (rst=1 at a clk edge):
  - FIFO emptied; pred_valid=0, pred_taken=0.
  - lookup_ready=0, tbl_en=0, tbl_we=0.
  - FSM enters CLEAR with clear counter=0; busy=1.
- FSM states: CLEAR, IDLE, UPD_RD, UPD_WR.
- CLEAR:
  - One write per cycle: tbl_en=1, tbl_we=1, tbl_addr=counter, tbl_wdata=INIT_STATE.
  - Counter increments; after entry 2**LOWER-1, go to IDLE and busy=0.
  - Takes exactly 2**LOWER cycles.
  - lookup_ready=0 throughout.
  - upd_ready=0 throughout; no pushes are accepted.
- IDLE:
  - lookup_ready = lookup_req && !fifo_full.
  - On an accepted lookup: tbl_en=1, tbl_we=0, tbl_addr=lookup_addr. Next cycle: pred_valid=1, pred_taken=tbl_rdata[1].
  - Otherwise, if the FIFO is non-empty (including when full): go to UPD_RD.
  - Arbitration: lookups win unless the FIFO is full; a full FIFO forces the update path.
- UPD_RD:
  - tbl_en=1, tbl_we=0, tbl_addr=FIFO head addr; lookup_ready=0.
  - Next state UPD_WR.
- UPD_WR:
  - tbl_en=1, tbl_we=1, tbl_addr=head addr, tbl_wdata=next(tbl_rdata, head taken); lookup_ready=0.
  - Pop the FIFO; next state IDLE.
- Counter arithmetic: taken → min(s+1, 3); not taken → max(s-1, 0). Saturates at 3 and 0, never wraps.
- Prediction: taken iff bit 1 of the state.
- pred_valid is only ever a one-cycle pulse following an accepted lookup.
- FIFO:
  - upd_ready = !full && state≠CLEAR.
  - Pushing and popping in the same cycle is legal; count is unchanged and the pointers wrap modulo QDEPTH.
  - A push to a full FIFO is impossible because upd_ready=0.
- Update ordering: updates to the same index apply strictly in arrival order. An update is never merged with, or overtaken by, another update.
- flush:
  - In IDLE or UPD_RD: empty the FIFO and go to CLEAR; no write is issued for the aborted update.
  - In UPD_WR: complete the write this cycle, then empty the FIFO and go to CLEAR.
  - In CLEAR: restart the counter at 0.
  - A lookup accepted in the flush cycle still produces its pred_valid the following cycle.
- rst overrides flush and all other inputs.

Test Plan:
- Reset, LOWER=5 → busy=1 for exactly 32 cycles; tbl_we=1 with addr 0..31 and wdata=01; then lookup at addr 7 → pred_valid=1, pred_taken=0 the next cycle.
- Update addr 3 taken twice with no lookups → RMW writes 10 then 11; a subsequent lookup at 3 → pred_taken=1. A third taken update → stays 11.
- Addr 3 at 11, four not-taken updates → writes 10, 01, 00, 00 (saturation at 0).
- Continuous lookup_req with 4 updates pushed (QDEPTH=4) → lookup_ready drops when full; UPD_RD/UPD_WR run; lookup_ready returns after the pop, and upd_ready=0 while full.
- Simultaneous push and pop in UPD_WR with FIFO count 2 → count stays 2; the wrapped pointer's entry is applied in order.
- flush asserted during UPD_RD with 3 queued updates → no write for the head; FIFO empty; 32 clear cycles; all entries read back 01.
